mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares port A of the 64 KB dual-port data memory between two requesters: requester 0 is the CPU load/store unit and requester 1 is the debug/loader engine. The block arbitrates round-robin and latches one request at a time. It drives the memory's word address, byte enables, write data and write enable, handles byte/halfword/word lane alignment, and returns aligned, optionally sign-extended read data. Port B (instruction fetch) is not touched by this block.

## Interface
Parameters:
- none (memory geometry fixed: 14-bit word address, 32-bit data, 4 byte lanes)

Ports (clock and reset: one clock; reset is synchronous and active-low):
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- req0, req1  in  1  request from requester 0 / 1, held high until ack
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  16  byte address
- size0, size1  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (error)
- sext0, sext1  in  1  load sign-extend enable (ignored for word and for stores)
- wdata0, wdata1  in  32  store data, right-aligned
- ack0, ack1  out  1  one-cycle completion pulse
- err  out  1  valid with ack: misaligned or reserved size; no memory access made
- rdata  out  32  load result, valid with ack (shared by both requesters)
- mem_address  out  14  connects to address_a
- mem_byteena  out  4  connects to byteena_a
- mem_data  out  32  connects to data_a
- mem_wren  out  1  connects to wren_a
- mem_q  in  32  from q_a (1-cycle registered read)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester not granted last; the pointer resets to favour requester 0. Latch we/addr/size/sext/wdata and the grant id, then go to ACCESS. With no request, stay in IDLE.
- Alignment check at latch: halfword with addr[0]=1, word with addr[1:0]≠0, or size=11 sets the error flag.
- ACCESS: drive mem_address=addr[15:2] from registered outputs.
  - Byte byteena: 0001<<addr[1:0]. Halfword: 0011<<addr[1:0]. Word: 1111.
  - Store: mem_data = wdata shifted left by 8*addr[1:0]; mem_wren=1 for this cycle only.
  - Load: mem_wren=0.
  - Error: mem_byteena=0000 and mem_wren=0.
  - Go to DONE.
- DONE: mem_q is valid. Load result = mem_q >> 8*addr[1:0], masked to the size.
  - If sext=1, bit 7 (byte) or bit 15 (halfword) is replicated upward; otherwise zero-extend.
  - Register rdata.
  - Pulse ack of the granted id (with err if flagged).
  - Update the round-robin pointer and go to IDLE.
- Stores and errors return rdata=0.
- A requester must drop req in the cycle it sees ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- Inputs are sampled only in IDLE; changes to a latched requester's inputs after the grant are ignored.

## Timing
- Reset values: ack0=ack1=0, err=0, rdata=0, mem_address=0, mem_byteena=0, mem_data=0, mem_wren=0, state IDLE, pointer favours 0.
- Latency: req sampled high in IDLE at edge N → memory signals driven after edge N+1 → ack/rdata/err valid after edge N+2 for one cycle.
- Throughput: one transaction per 3 cycles.
- mem_wren is high for exactly one cycle per store and never on error.
- Reset mid-operation: all state clears at the reset edge and no ack is issued for the aborted request. A store whose mem_wren was already high at that edge is committed by the memory.
- ack0 and ack1 are never high together.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req0=1 → all outputs 0, no ack; release → ack0 two cycles after the first IDLE sample.
- Word store/load: req0 we=1 addr=0x0010 size=10 wdata=0xDEADBEEF → mem_address=0x0004, byteena=1111, mem_wren=1 for one cycle. Then load addr=0x0010 → rdata=0xDEADBEEF, err=0.
- Byte store/load: store byte 0x80 at addr=0x0013 → byteena=1000, mem_data[31:24]=0x80. Load sext=1 → rdata=0xFFFFFF80; sext=0 → 0x00000080.
- Halfword: store 0x1234 at 0x0022 → byteena=1100; load → 0x00001234.
- Misaligned: req1 word load at 0x0001 → ack1+err after 2 cycles, byteena=0000, mem_wren never 1; halfword at 0x0003 → err.
- Contention: req0 and req1 held continuously → grants alternate 0,1,0,1; with only req1 → all grants to 1; never a double ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port A between the CPU load/store unit and the debug engine.
// Each request takes three cycles: latch in IDLE, drive the memory in ACCESS, return data in DONE.
module mem_port_arbiter (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [1:0]  size0,
   input  logic [1:0]  size1,
   input  logic        sext0,
   input  logic        sext1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [31:0] rdata,
   output logic [13:0] mem_address,
   output logic [3:0]  mem_byteena,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   state_t      state_next;

   logic        last_grant;
   logic        grant_id;
   logic        lat_we;
   logic        lat_sext;
   logic        lat_err;
   logic [15:0] lat_addr;
   logic [1:0]  lat_size;
   logic [31:0] lat_wdata;

   logic        sel_id;
   logic        sel_we;
   logic        sel_sext;
   logic        sel_err;
   logic [15:0] sel_addr;
   logic [1:0]  sel_size;
   logic [31:0] sel_wdata;

   logic [3:0]  lane_en;
   logic [31:0] store_data;
   logic [31:0] load_shifted;
   logic [31:0] load_value;

   // last_grant == 1 means requester 0 wins the next tie.
   always_comb begin
      sel_id = 1'b0;
      if (req0 && req1) begin
         sel_id = ~last_grant;
      end else if (req1) begin
         sel_id = 1'b1;
      end
      sel_we    = sel_id ? we1    : we0;
      sel_addr  = sel_id ? addr1  : addr0;
      sel_size  = sel_id ? size1  : size0;
      sel_sext  = sel_id ? sext1  : sext0;
      sel_wdata = sel_id ? wdata1 : wdata0;
      sel_err   = 1'b0;
      case (sel_size)
         2'b00:   sel_err = 1'b0;
         2'b01:   sel_err = sel_addr[0];
         2'b10:   sel_err = |sel_addr[1:0];
         default: sel_err = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req0 || req1) state_next = ACCESS;
         ACCESS:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane placement for stores and lane extraction for loads, both from the latched request.
   always_comb begin
      lane_en = 4'b0000;
      case (lat_size)
         2'b00:   lane_en = 4'b0001 << lat_addr[1:0];
         2'b01:   lane_en = 4'b0011 << lat_addr[1:0];
         2'b10:   lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
      store_data   = lat_wdata << {lat_addr[1:0], 3'b000};
      load_shifted = mem_q >> {lat_addr[1:0], 3'b000};
      load_value   = load_shifted;
      case (lat_size)
         2'b00:   load_value = {{24{lat_sext & load_shifted[7]}}, load_shifted[7:0]};
         2'b01:   load_value = {{16{lat_sext & load_shifted[15]}}, load_shifted[15:0]};
         default: load_value = load_shifted;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         lat_we      <= 1'b0;
         lat_sext    <= 1'b0;
         lat_err     <= 1'b0;
         lat_addr    <= 16'h0000;
         lat_size    <= 2'b00;
         lat_wdata   <= 32'h0000_0000;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err         <= 1'b0;
         rdata       <= 32'h0000_0000;
         mem_address <= 14'h0000;
         mem_byteena <= 4'b0000;
         mem_data    <= 32'h0000_0000;
         mem_wren    <= 1'b0;
      end else begin
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err      <= 1'b0;
         mem_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant_id  <= sel_id;
                  lat_we    <= sel_we;
                  lat_sext  <= sel_sext;
                  lat_err   <= sel_err;
                  lat_addr  <= sel_addr;
                  lat_size  <= sel_size;
                  lat_wdata <= sel_wdata;
               end
            end
            ACCESS: begin
               mem_address <= lat_addr[15:2];
               mem_byteena <= lat_err ? 4'b0000 : lane_en;
               mem_data    <= lat_we ? store_data : 32'h0000_0000;
               mem_wren    <= lat_we & ~lat_err;
            end
            DONE: begin
               ack0        <= ~grant_id;
               ack1        <= grant_id;
               err         <= lat_err;
               rdata       <= (lat_we || lat_err) ? 32'h0000_0000 : load_value;
               last_grant  <= grant_id;
               mem_byteena <= 4'b0000;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled memory model behind port A.
// The model returns mem_q from the arbiter's registered address and commits stores on the clock edge.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset_n;
   logic        req0, req1, we0, we1, sext0, sext1;
   logic [15:0] addr0, addr1;
   logic [1:0]  size0, size1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, err, mem_wren;
   logic [31:0] rdata, mem_data, mem_q;
   logic [13:0] mem_address;
   logic [3:0]  mem_byteena;

   logic [31:0] mem [0:16383];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [15:0] addr;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_data;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vectors [21];

   mem_port_arbiter dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0        (req0),
      .req1        (req1),
      .we0         (we0),
      .we1         (we1),
      .addr0       (addr0),
      .addr1       (addr1),
      .size0       (size0),
      .size1       (size1),
      .sext0       (sext0),
      .sext1       (sext1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .ack0        (ack0),
      .ack1        (ack1),
      .err         (err),
      .rdata       (rdata),
      .mem_address (mem_address),
      .mem_byteena (mem_byteena),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign mem_q = mem[mem_address];

   always @(posedge clock) begin
      if (mem_wren) begin
         if (mem_byteena[0]) mem[mem_address][7:0]   <= mem_data[7:0];
         if (mem_byteena[1]) mem[mem_address][15:8]  <= mem_data[15:8];
         if (mem_byteena[2]) mem[mem_address][23:16] <= mem_data[23:16];
         if (mem_byteena[3]) mem[mem_address][31:24] <= mem_data[31:24];
      end
   end

   function automatic logic [31:0] laneMask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic clearRequests();
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; size0 = 2'b00; sext0 = 1'b0; wdata0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; size1 = 2'b00; sext1 = 1'b0; wdata1 = 32'h0;
   endtask

   task automatic driveRequest(input logic port, input logic we, input logic [15:0] addr,
                               input logic [1:0] size, input logic sext, input logic [31:0] wdata);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; size1 = size; sext1 = sext; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; size0 = size; sext0 = sext; wdata0 = wdata;
      end
   endtask

   // One full transaction: grant edge, access edge, completion edge, each checked 1 ns later.
   task automatic applyStimulus(input int idx, input vec_t v);
      logic exp_wren;
      exp_wren = v.we & ~v.exp_err;
      @(negedge clock);
      driveRequest(v.port, v.we, v.addr, v.size, v.sext, v.wdata);
      @(posedge clock); #1;
      checkOutput($sformatf("v%0d_no_early_ack", idx), {31'b0, ack0 | ack1}, 32'd0);
      @(posedge clock); #1;
      checkOutput($sformatf("v%0d_mem_address", idx), {18'b0, mem_address}, {18'b0, v.addr[15:2]});
      checkOutput($sformatf("v%0d_byteena", idx), {28'b0, mem_byteena}, {28'b0, v.exp_be});
      checkOutput($sformatf("v%0d_wren", idx), {31'b0, mem_wren}, {31'b0, exp_wren});
      if (exp_wren)
         checkOutput($sformatf("v%0d_mem_data", idx), mem_data & laneMask(v.exp_be),
                     v.exp_data & laneMask(v.exp_be));
      @(posedge clock); #1;
      checkOutput($sformatf("v%0d_ack_granted", idx), {31'b0, v.port ? ack1 : ack0}, 32'd1);
      checkOutput($sformatf("v%0d_ack_other", idx), {31'b0, v.port ? ack0 : ack1}, 32'd0);
      checkOutput($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.exp_err});
      checkOutput($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      checkOutput($sformatf("v%0d_wren_off", idx), {31'b0, mem_wren}, 32'd0);
      clearRequests();
   endtask

   initial begin
      int acks_seen;

      vectors[0]  = '{1'b0, 1'b1, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
      vectors[1]  = '{1'b0, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0,        4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vectors[2]  = '{1'b0, 1'b1, 16'h0013, 2'b00, 1'b0, 32'h00000080, 4'h8, 32'h80000000, 32'h0,        1'b0};
      vectors[3]  = '{1'b0, 1'b0, 16'h0013, 2'b00, 1'b1, 32'h0,        4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
      vectors[4]  = '{1'b1, 1'b0, 16'h0013, 2'b00, 1'b0, 32'h0,        4'h8, 32'h0,        32'h00000080, 1'b0};
      vectors[5]  = '{1'b1, 1'b1, 16'h0022, 2'b01, 1'b0, 32'h00001234, 4'hC, 32'h12340000, 32'h0,        1'b0};
      vectors[6]  = '{1'b1, 1'b0, 16'h0022, 2'b01, 1'b0, 32'h0,        4'hC, 32'h0,        32'h00001234, 1'b0};
      vectors[7]  = '{1'b0, 1'b1, 16'h0020, 2'b01, 1'b0, 32'h00008001, 4'h3, 32'h00008001, 32'h0,        1'b0};
      vectors[8]  = '{1'b0, 1'b0, 16'h0020, 2'b01, 1'b1, 32'h0,        4'h3, 32'h0,        32'hFFFF8001, 1'b0};
      vectors[9]  = '{1'b1, 1'b0, 16'h0020, 2'b10, 1'b0, 32'h0,        4'hF, 32'h0,        32'h12348001, 1'b0};
      vectors[10] = '{1'b1, 1'b0, 16'h0001, 2'b10, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
      vectors[11] = '{1'b1, 1'b0, 16'h0003, 2'b01, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
      vectors[12] = '{1'b0, 1'b1, 16'h0012, 2'b10, 1'b0, 32'h11111111, 4'h0, 32'h0,        32'h0,        1'b1};
      vectors[13] = '{1'b0, 1'b0, 16'h0014, 2'b11, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
      vectors[14] = '{1'b0, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0,        4'hF, 32'h0,        32'h80ADBEEF, 1'b0};
      vectors[15] = '{1'b1, 1'b0, 16'h0011, 2'b00, 1'b1, 32'h0,        4'h2, 32'h0,        32'hFFFFFFBE, 1'b0};
      vectors[16] = '{1'b0, 1'b0, 16'h0012, 2'b00, 1'b1, 32'h0,        4'h4, 32'h0,        32'hFFFFFFAD, 1'b0};
      vectors[17] = '{1'b1, 1'b0, 16'h0012, 2'b01, 1'b0, 32'h0,        4'hC, 32'h0,        32'h000080AD, 1'b0};
      vectors[18] = '{1'b1, 1'b1, 16'h0021, 2'b00, 1'b0, 32'hFFFFFF55, 4'h2, 32'h00005500, 32'h0,        1'b0};
      vectors[19] = '{1'b0, 1'b0, 16'h0020, 2'b10, 1'b0, 32'h0,        4'hF, 32'h0,        32'h12345501, 1'b0};
      vectors[20] = '{1'b0, 1'b0, 16'h0012, 2'b01, 1'b1, 32'h0,        4'hC, 32'h0,        32'hFFFF80AD, 1'b0};

      // Reset held for two cycles with a pending request.
      clearRequests();
      reset_n = 1'b0;
      driveRequest(1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 32'h0);
      @(posedge clock); #1;
      checkOutput("rst_ack0_c1", {31'b0, ack0}, 32'd0);
      @(posedge clock); #1;
      checkOutput("rst_ack0", {31'b0, ack0}, 32'd0);
      checkOutput("rst_ack1", {31'b0, ack1}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      checkOutput("rst_mem_address", {18'b0, mem_address}, 32'd0);
      checkOutput("rst_byteena", {28'b0, mem_byteena}, 32'd0);
      checkOutput("rst_mem_data", mem_data, 32'd0);
      checkOutput("rst_wren", {31'b0, mem_wren}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("post_rst_no_ack_n", {31'b0, ack0 | ack1}, 32'd0);
      @(posedge clock); #1;
      checkOutput("post_rst_no_ack_n1", {31'b0, ack0 | ack1}, 32'd0);
      @(posedge clock); #1;
      checkOutput("post_rst_ack0", {31'b0, ack0}, 32'd1);
      checkOutput("post_rst_ack1", {31'b0, ack1}, 32'd0);
      clearRequests();

      for (int i = 0; i < 21; i++) begin
         applyStimulus(i, vectors[i]);
      end

      // Reset lands on the edge where a store's mem_wren is high; the store commits, no ack follows.
      @(negedge clock);
      driveRequest(1'b0, 1'b1, 16'h0040, 2'b10, 1'b0, 32'hCAFEF00D);
      @(posedge clock);
      @(posedge clock); #1;
      checkOutput("midrst_wren_before", {31'b0, mem_wren}, 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      clearRequests();
      @(posedge clock); #1;
      checkOutput("midrst_no_ack", {31'b0, ack0 | ack1}, 32'd0);
      checkOutput("midrst_wren_cleared", {31'b0, mem_wren}, 32'd0);
      checkOutput("midrst_byteena_cleared", {28'b0, mem_byteena}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("midrst_no_late_ack", {31'b0, ack0 | ack1}, 32'd0);

      // Both requesters hold req; grants must alternate starting with requester 0.
      @(negedge clock);
      driveRequest(1'b0, 1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
      driveRequest(1'b1, 1'b0, 16'h0040, 2'b10, 1'b0, 32'h0);
      acks_seen = 0;
      for (int k = 0; k < 14 && acks_seen < 4; k++) begin
         @(posedge clock); #1;
         checkOutput("rr_no_double_ack", {31'b0, ack0 & ack1}, 32'd0);
         if (ack0 || ack1) begin
            checkOutput($sformatf("rr_grant%0d", acks_seen), {31'b0, ack1}, 32'(acks_seen % 2));
            checkOutput($sformatf("rr_rdata%0d", acks_seen), rdata,
                        (acks_seen % 2 == 1) ? 32'hCAFEF00D : 32'h80ADBEEF);
            acks_seen++;
            if (acks_seen == 4) clearRequests();
         end
      end
      checkOutput("rr_ack_count", 32'(acks_seen), 32'd4);
      clearRequests();

      // Only requester 1 asking: every grant goes to it.
      @(negedge clock);
      driveRequest(1'b1, 1'b0, 16'h0040, 2'b10, 1'b0, 32'h0);
      acks_seen = 0;
      for (int k = 0; k < 12 && acks_seen < 3; k++) begin
         @(posedge clock); #1;
         checkOutput("only1_no_ack0", {31'b0, ack0}, 32'd0);
         if (ack1) begin
            checkOutput($sformatf("only1_rdata%0d", acks_seen), rdata, 32'hCAFEF00D);
            acks_seen++;
            if (acks_seen == 3) clearRequests();
         end
      end
      checkOutput("only1_ack_count", 32'(acks_seen), 32'd3);
      clearRequests();

      repeat (2) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
